axis_trigger_capture: RTL and testbench
=======================================

// Module: axis_trigger_capture
// PURPOSE
//  Capture controller placed directly downstream of the level trigger stage.
//  Forwards a sample stream to a ring buffer writer and tracks a wrapping
//  write address. After an arm, fills a pre-trigger window, waits for
//  trg_flag, then forwards a fixed number of post-trigger samples.
//  Reports the buffer address of the trigger sample and a done flag.
// PARAMETERS
//  AXIS_TDATA_WIDTH  32  sample width, bits
//  CNTR_WIDTH        16  width of the address and length counters
// PORTS
//  aclk           in   1                 clock; everything is on its rising edge
//  aresetn        in   1                 asynchronous, active-low reset
//  run_flag       in   1                 level: 1 = arm/keep armed, 0 = stop/abort
//  pre_data       in   CNTR_WIDTH        pre-trigger sample count
//  post_data      in   CNTR_WIDTH        post-trigger count, trigger sample included (0 treated as 1)
//  trg_flag       in   1                 trigger pulse, qualified by s_axis_tvalid
//  trg_force      in   1                 software trigger, same qualification
//  sts_addr       out  CNTR_WIDTH        address of the trigger sample
//  sts_done       out  1                 capture complete
//  s_axis_tready  out  1                 constant 1
//  s_axis_tdata   in   AXIS_TDATA_WIDTH  input sample
//  s_axis_tvalid  in   1                 input beat valid
//  m_axis_tdata   out  AXIS_TDATA_WIDTH  forwarded sample
//  m_axis_tvalid  out  1                 forwarded beat valid
//  m_axis_tlast   out  1                 final post-trigger beat
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state IDLE; addr, cnt, sts_addr and all m_axis_* = 0; sts_done = 0.
//  Beat: a cycle with s_axis_tvalid=1. No backpressure; the sink is always ready.
//  States:
//   - IDLE: no beats forwarded. run_flag=1 -> PRE; addr and cnt cleared to 0.
//   - PRE: each beat forwarded at address addr; addr++ and cnt++.
//     -> WAIT on the beat where cnt+1 == pre_data.
//     pre_data=0 -> WAIT on the cycle after arm, with no beats consumed.
//     trg_flag and trg_force are ignored in PRE.
//   - WAIT: each beat forwarded; addr++.
//     Trigger = beat with (trg_flag | trg_force); sts_addr <= addr of that beat.
//     The trigger beat is post sample 1 (cnt <= 1); next state POST.
//     If post_data <= 1: the trigger beat carries tlast and next state is DONE.
//   - POST: each beat forwarded; addr++ and cnt++.
//     The beat with cnt == post_data carries tlast -> DONE.
//     Triggers are ignored in POST.
//   - DONE: no beats forwarded; sts_done=1; sts_addr held.
//     run_flag=0 -> IDLE; sts_done clears on the same transition.
//  Abort:
//   - run_flag=0 in PRE, WAIT or POST -> IDLE on the next edge.
//   - The beat in that cycle is not forwarded and no tlast is emitted.
//   - sts_done stays 0; sts_addr keeps its last value.
//  Output pipeline: m_axis_tdata/tvalid/tlast are registered, 1-cycle latency.
//   - m_axis_tvalid = beat in PRE/WAIT/POST, registered.
//   - m_axis_tdata updates only on forwarded beats.
//   - m_axis_tlast is 1 only together with m_axis_tvalid.
//  Arithmetic: addr wraps modulo 2^CNTR_WIDTH (all-ones -> 0 with no flag).
//   - cnt is CNTR_WIDTH bits and never exceeds max(pre_data, post_data).
//  pre_data and post_data are sampled continuously. Changing them mid-capture
//   is undefined for the bench; software changes them only in IDLE.
//  Simultaneous trg_flag and trg_force count as one trigger.
//  A trigger on the cycle the FSM leaves PRE is ignored.
// TESTING
//  1. pre=4, post=3, continuous tvalid, trigger on the 7th beat (addr 6)
//     -> 9 beats out, tlast on addr 8, sts_addr=6, sts_done=1.
//  2. pre=0, post=1, trg_force on the first beat
//     -> exactly 1 beat out with tlast, sts_addr=0, DONE.
//  3. Trigger asserted during PRE beats 0..3 and none after
//     -> stays in WAIT; sts_done=0; beats keep flowing.
//  4. CNTR_WIDTH=4, pre=14, trigger at addr 15, post=3
//     -> addresses 15,0,1 post-trigger; sts_addr=15; tlast on the addr 1 beat.
//  5. run_flag dropped in POST after 1 of 5 post beats
//     -> IDLE next cycle, no tlast, sts_done=0; re-arm restarts at addr 0.
//  6. tvalid toggled 1,0,1,0 with aresetn pulsed low mid-WAIT
//     -> outputs 0 immediately; gaps do not advance addr or cnt; IDLE after release.

Source files
------------

// File: rtl/axis_trigger_capture.sv
`timescale 1ns/1ps
// axis_trigger_capture
//   Capture controller behind the level trigger stage. It forwards samples to a
//   ring buffer writer while tracking a wrapping write address. After an arm it
//   fills a pre-trigger window, waits for a trigger, then forwards a fixed
//   number of post-trigger samples. It reports the trigger sample address and
//   a done flag.
// Ports
//   aclk, aresetn       clock, asynchronous active-low reset
//   run_flag            level: 1 arms / keeps armed, 0 stops or aborts
//   pre_data, post_data pre-trigger count, post-trigger count (trigger included)
//   trg_flag, trg_force hardware and software trigger, qualified by tvalid
//   sts_addr, sts_done  trigger sample address, capture complete
//   s_axis_*            input stream (tready is always 1)
//   m_axis_*            forwarded stream, registered with 1-cycle latency
module axis_trigger_capture #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        run_flag,
  input  logic [CNTR_WIDTH-1:0]       pre_data,
  input  logic [CNTR_WIDTH-1:0]       post_data,
  input  logic                        trg_flag,
  input  logic                        trg_force,
  output logic [CNTR_WIDTH-1:0]       sts_addr,
  output logic                        sts_done,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [CNTR_WIDTH-1:0]       addr_q, addr_d;
  logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]       sts_addr_q, sts_addr_d;
  logic                        sts_done_q, sts_done_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [CNTR_WIDTH-1:0]       cnt_inc;

  assign cnt_inc = cnt_q + ONE;

  // Next-state and output decode; a cleared run_flag aborts any active phase
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sts_addr_d = sts_addr_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_flag) begin
          state_d = S_PRE;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        if (!run_flag) begin
          state_d = S_IDLE;
        end else if (pre_data == '0) begin
          // Empty pre-trigger window: move on without consuming a beat
          state_d = S_WAIT;
        end else if (s_axis_tvalid) begin
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata;
          addr_d   = addr_q + ONE;
          cnt_d    = cnt_inc;
          if (cnt_inc == pre_data) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!run_flag) begin
          state_d = S_IDLE;
        end else if (s_axis_tvalid) begin
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata;
          addr_d   = addr_q + ONE;
          if (trg_flag || trg_force) begin
            // Trigger beat is post sample 1
            sts_addr_d = addr_q;
            cnt_d      = ONE;
            if (post_data <= ONE) begin
              tlast_d = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
            end
          end
        end
      end
      S_POST: begin
        if (!run_flag) begin
          state_d = S_IDLE;
        end else if (s_axis_tvalid) begin
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata;
          addr_d   = addr_q + ONE;
          cnt_d    = cnt_inc;
          if (cnt_inc == post_data) begin
            tlast_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!run_flag) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    sts_done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      sts_addr_q <= '0;
      sts_done_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sts_addr_q <= sts_addr_d;
      sts_done_q <= sts_done_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign s_axis_tready = 1'b1;
  assign sts_addr      = sts_addr_q;
  assign sts_done      = sts_done_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_trigger_capture.sv
`timescale 1ns/1ps
// Bench for axis_trigger_capture: a 16-bit-counter instance (A) and a 4-bit
// instance (B) share the input stream; stimulus pushes expected beats into a
// per-instance queue and a negedge monitor pops and compares output beats.
module tb_axis_trigger_capture;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid, trg_flag, trg_force;

  logic        run_a, run_b;
  logic [15:0] pre_a, post_a;
  logic [3:0]  pre_b, post_b;

  logic [15:0] sts_addr_a;
  logic [3:0]  sts_addr_b;
  logic        sts_done_a, sts_done_b, tready_a, tready_b;
  logic [31:0] m_tdata_a, m_tdata_b;
  logic        m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 aclk = ~aclk;

  axis_trigger_capture #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .run_flag(run_a),
    .pre_data(pre_a), .post_data(post_a),
    .trg_flag(trg_flag), .trg_force(trg_force),
    .sts_addr(sts_addr_a), .sts_done(sts_done_a), .s_axis_tready(tready_a),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tlast(m_tlast_a)
  );

  axis_trigger_capture #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(4)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .run_flag(run_b),
    .pre_data(pre_b), .post_data(post_b),
    .trg_flag(trg_flag), .trg_force(trg_force),
    .sts_addr(sts_addr_b), .sts_done(sts_done_b), .s_axis_tready(tready_b),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tlast(m_tlast_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; fwd/last describe the expected output beat
  task automatic cyc(input bit sel_b, input logic v, input logic [31:0] d,
                     input logic trg, input logic frc, input bit fwd, input bit last);
    exp_t e;
    s_tvalid  = v;
    s_tdata   = d;
    trg_flag  = trg;
    trg_force = frc;
    e.data = d;
    e.last = last;
    if (fwd) begin
      if (sel_b) q_b.push_back(e);
      else       q_a.push_back(e);
    end
    @(negedge aclk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor for instance A
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn) begin
      if (m_tvalid_a) begin
        checks++;
        if (q_a.size() == 0) begin
          failures++;
          $display("FAIL beat_a: unexpected beat data 0x%0h last %0b", m_tdata_a, m_tlast_a);
        end else begin
          e = q_a.pop_front();
          if (m_tdata_a !== e.data || m_tlast_a !== e.last) begin
            failures++;
            $display("FAIL beat_a: got data 0x%0h last %0b expected data 0x%0h last %0b",
                     m_tdata_a, m_tlast_a, e.data, e.last);
          end
        end
      end else if (m_tlast_a) begin
        checks++;
        failures++;
        $display("FAIL tlast_a: got tlast 1 without tvalid expected 0");
      end
    end
  end

  // Monitor for instance B
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn) begin
      if (m_tvalid_b) begin
        checks++;
        if (q_b.size() == 0) begin
          failures++;
          $display("FAIL beat_b: unexpected beat data 0x%0h last %0b", m_tdata_b, m_tlast_b);
        end else begin
          e = q_b.pop_front();
          if (m_tdata_b !== e.data || m_tlast_b !== e.last) begin
            failures++;
            $display("FAIL beat_b: got data 0x%0h last %0b expected data 0x%0h last %0b",
                     m_tdata_b, m_tlast_b, e.data, e.last);
          end
        end
      end else if (m_tlast_b) begin
        checks++;
        failures++;
        $display("FAIL tlast_b: got tlast 1 without tvalid expected 0");
      end
    end
  end

  initial begin
    aresetn = 1'b0;
    run_a = 1'b0; run_b = 1'b0;
    pre_a = '0; post_a = '0; pre_b = '0; post_b = '0;
    s_tdata = '0; s_tvalid = 1'b0; trg_flag = 1'b0; trg_force = 1'b0;
    repeat (2) @(negedge aclk);

    // Reset state
    chk("rst_sts_addr", 32'(sts_addr_a), 32'h0);
    chk("rst_sts_done", 32'(sts_done_a), 32'h0);
    chk("rst_tvalid", 32'(m_tvalid_a), 32'h0);
    chk("rst_tlast", 32'(m_tlast_a), 32'h0);
    chk("rst_tdata", m_tdata_a, 32'h0);
    chk("tready", 32'(tready_a), 32'h1);
    aresetn = 1'b1;
    idle();

    // 1: pre=4 post=3, trigger on 7th beat (addr 6), tlast at addr 8
    pre_a = 16'd4; post_a = 16'd3; run_a = 1'b1;
    idle();
    for (int i = 0; i < 9; i++)
      cyc(1'b0, 1'b1, 32'(32'h100 + i), 1'(i == 6), 1'b0, 1'b1, 1'(i == 8));
    cyc(1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_sts_addr", 32'(sts_addr_a), 32'd6);
    chk("t1_sts_done", 32'(sts_done_a), 32'h1);
    run_a = 1'b0;
    idle();
    chk("t1_done_clear", 32'(sts_done_a), 32'h0);
    chk("t1_addr_held", 32'(sts_addr_a), 32'd6);

    // 3: triggers only during PRE beats 0..3 are ignored
    pre_a = 16'd4; post_a = 16'd3; run_a = 1'b1;
    idle();
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 32'(32'h200 + i), 1'(i < 4), 1'b0, 1'b1, 1'b0);
    chk("t3_sts_done", 32'(sts_done_a), 32'h0);
    chk("t3_sts_addr", 32'(sts_addr_a), 32'd6);
    run_a = 1'b0;
    idle();

    // 5: abort in POST after the trigger beat (1 of 5)
    pre_a = 16'd2; post_a = 16'd5; run_a = 1'b1;
    idle();
    cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h301, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h302, 1'b1, 1'b0, 1'b1, 1'b0);
    run_a = 1'b0;
    cyc(1'b0, 1'b1, 32'h3FF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t5_sts_done", 32'(sts_done_a), 32'h0);
    chk("t5_sts_addr", 32'(sts_addr_a), 32'd2);

    // 2: pre=0 post=1, forced trigger on first consumed beat; addr restarts at 0
    pre_a = 16'd0; post_a = 16'd1; run_a = 1'b1;
    idle();
    cyc(1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h401, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 32'h402, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_sts_addr", 32'(sts_addr_a), 32'd0);
    chk("t2_sts_done", 32'(sts_done_a), 32'h1);
    run_a = 1'b0;
    idle();
    chk("t2_done_clear", 32'(sts_done_a), 32'h0);

    // 6a: gaps do not advance addr/cnt; simultaneous triggers count once
    pre_a = 16'd2; post_a = 16'd2; run_a = 1'b1;
    idle();
    cyc(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h5F0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h501, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h5F1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h502, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h5F2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h503, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_sts_addr", 32'(sts_addr_a), 32'd2);
    chk("t6_sts_done", 32'(sts_done_a), 32'h1);
    run_a = 1'b0;
    idle();

    // 6b: asynchronous reset mid-WAIT clears outputs at once
    pre_a = 16'd1; post_a = 16'd2; run_a = 1'b1;
    idle();
    cyc(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h601, 1'b0, 1'b0, 1'b1, 1'b0);
    s_tvalid = 1'b1; s_tdata = 32'h602;
    @(posedge aclk);
    #1;
    chk("t6_pre_rst_tvalid", 32'(m_tvalid_a), 32'h1);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(m_tvalid_a), 32'h0);
    chk("t6_rst_tdata", m_tdata_a, 32'h0);
    chk("t6_rst_sts_addr", 32'(sts_addr_a), 32'h0);
    run_a = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    cyc(1'b0, 1'b1, 32'h603, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_idle_tvalid", 32'(m_tvalid_a), 32'h0);
    chk("t6_idle_done", 32'(sts_done_a), 32'h0);

    // 4: 4-bit counters, pre=14, trigger at addr 15, post beats at 0 and 1
    pre_b = 4'd14; post_b = 4'd3; run_b = 1'b1;
    idle();
    for (int i = 0; i < 18; i++)
      cyc(1'b1, 1'b1, 32'(32'h700 + i), 1'(i == 15), 1'b0, 1'b1, 1'(i == 17));
    cyc(1'b1, 1'b1, 32'h7FF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_sts_addr", 32'(sts_addr_b), 32'd15);
    chk("t4_sts_done", 32'(sts_done_b), 32'h1);
    run_b = 1'b0;
    idle();
    chk("t4_done_clear", 32'(sts_done_b), 32'h0);

    idle();
    chk("drain_a", 32'(q_a.size()), 32'h0);
    chk("drain_b", 32'(q_b.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
